reg_file_wb: RTL and testbench

// - MIPS integer register file: the write-back end of the datapath.
// - The operand-select muxes read from this block; this block decodes the write-back

---
 rtl/reg_file_wb_pkg.sv | 12 +
 rtl/reg_file_wb_wr_decoder.sv | 24 ++
 rtl/reg_file_wb.sv | 76 +++++++
 tb/tb_reg_file_wb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the MIPS integer register file: default geometry and the
// architectural register indices used by decode and link logic.
package reg_file_wb_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

endpackage : reg_file_wb_pkg

// File: rtl/reg_file_wb_wr_decoder.sv
// Write-back destination decoder: one write strobe per register, gated by the
// write enable and by reset, with the zero register never strobed.
module reg_file_wb_wr_decoder
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic              we_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] waddr_i,
  output logic [DEPTH-1:0]  stb_o
);

  always_comb begin
    // NOTE: assigning a default before any condition keeps this block free of inferred latches.
    stb_o = '0;
    if (we_i && rst_n_i) begin
      stb_o[waddr_i] = 1'b1;
    end
    stb_o[REG_ZERO] = 1'b0;
  end

endmodule : reg_file_wb_wr_decoder

// File: rtl/reg_file_wb.sv
// MIPS integer register file: one synchronous write-back port, two combinational
// read ports with optional same-cycle write-to-read bypass; r0 always reads zero.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  wr_stb;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  reg_file_wb_wr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_decoder (
    .we_i    (we),
    .rst_n_i (rst_n),
    .waddr_i (waddr),
    .stb_o   (wr_stb)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = wr_stb[i] ? wdata : regs_q[i];
    end
  end

  // NOTE: this array is deliberately reset, since software relies on a cleared file;
  // memories without that need are usually left unreset so they can map to RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Both read ports share one mux-plus-bypass structure.
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic is_zero;
    logic bypass_hit;

    assign is_zero    = (raddr[p] == ADDR_W'(REG_ZERO));
    assign bypass_hit = (BYPASS != 0) && rst_n && we && (waddr == raddr[p]);
    assign rdata[p]   = is_zero    ? '0    :
                        bypass_hit ? wdata :
                                     regs_q[raddr[p]];
  end

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: a bypassing and a non-bypassing instance share
// all stimulus, and every read is compared against hand-computed values.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1_b, rdata2_b;
  logic [31:0] rdata1_n, rdata2_n;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1_b),
    .rdata2 (rdata2_b)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_n (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1_n),
    .rdata2 (rdata2_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] exp1, input logic [31:0] exp2);
    check({tag, " b.rd1"}, rdata1_b, exp1);
    check({tag, " b.rd2"}, rdata2_b, exp2);
    check({tag, " n.rd1"}, rdata1_n, exp1);
    check({tag, " n.rd2"}, rdata2_n, exp2);
  endtask

  initial begin
    rst_n  = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;
    tick();
    rst_n = 1'b1;

    raddr1 = 5'd5;
    raddr2 = 5'd31;
    #1 check_all("reset_state", 32'h0, 32'h0);

    // 1. reset clears previously written contents
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    #1 check_all("r5_written", 32'hDEAD_BEEF, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check_all("reset_clear", 32'h0, 32'h0);

    // 2. basic write, neighbour untouched
    we = 1'b1; waddr = 5'd8; wdata = 32'h0000_FFF0;
    raddr1 = 5'd8; raddr2 = 5'd9;
    tick();
    we = 1'b0;
    #1 check_all("write_r8", 32'h0000_FFF0, 32'h0);

    // 3. zero register ignores writes and never bypasses
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1 check_all("r0_pre", 32'h0, 32'h0);
    tick();
    we = 1'b0;
    #1 check_all("r0_post", 32'h0, 32'h0);

    // 4. same-cycle bypass on both ports
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick();
    wdata = 32'h22; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    check("byp b.rd1", rdata1_b, 32'h22);
    check("byp b.rd2", rdata2_b, 32'h22);
    check("nobyp n.rd1", rdata1_n, 32'h11);
    check("nobyp n.rd2", rdata2_n, 32'h11);
    tick();
    we = 1'b0;
    #1 check_all("byp_post", 32'h22, 32'h22);

    // 5. reset has priority over a simultaneous write and suppresses bypass
    rst_n = 1'b0; we = 1'b1; waddr = 5'd7; wdata = 32'hAB;
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1 check_all("rst_nobyp", 32'h0, 32'h0);
    tick();
    rst_n = 1'b1; we = 1'b0;
    #1 check_all("rst_beats_wr", 32'h0, 32'h0);
    raddr1 = 5'd3; raddr2 = 5'd8;
    #1 check_all("rst_midstream", 32'h0, 32'h0);

    // 6. sweep all registers, then read back on both ports
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = i * 32'h0101_0101;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1 check_all($sformatf("sweep_%0d", i),
                   (i == 0)  ? 32'h0 : i * 32'h0101_0101,
                   (i == 31) ? 32'h0 : (31 - i) * 32'h0101_0101);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_reg_file_wb
